// File: rtl/doodle_pkg.sv
// Shared constants, types and reset layout for the doodle platform world.
package doodle_pkg;

   localparam int N_PLAT      = 8;
   localparam int PLAT_IW     = $clog2(N_PLAT);
   localparam int H           = 240;
   localparam int SPACING     = 30;
   localparam int PLAT0_Y     = 210;
   localparam int PLAT_W      = 32;
   localparam int PLAT_H      = 4;
   localparam int DOODLE_W    = 10;
   localparam int DOODLE_H    = 10;
   localparam int X_MIN       = 80;
   localparam int X_MAX       = 239;
   localparam int SCROLL_LINE = 80;
   localparam int SCROLL_MAX  = 15;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
   } plat_t;

   typedef enum logic [1:0] {
      PF_IDLE,
      PF_SAMPLE,
      PF_SWEEP,
      PF_DONE
   } pf_state_e;

   // Power-on layout: evenly pitched column, pseudo-scattered X, plat 0 under the spawn.
   function automatic plat_t plat_init(input int i);
      plat_t p;
      p.y = 10'(PLAT0_Y - SPACING * i);
      p.x = 10'(X_MIN + ((37 * i + 64) % 128));
      return p;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, advances only when stepped.
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        step_i,
   output logic [15:0] state_o
);

   logic [15:0] state_q;
   logic [15:0] state_d;

   always_comb begin
      state_d = state_q;
      if (step_i) state_d = {state_q[14:0], state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10]};
   end

   // State register, reloads the nonzero seed on reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= SEED;
      else         state_q <= state_d;
   end

   assign state_o = state_q;

endmodule

// File: rtl/platform_field.sv
// Platform world: per-frame scroll, landing detection, wrap/respawn, score and game-over.
module platform_field
   import doodle_pkg::*;
(
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic [1:0]         frame_clk_edge,
   input  logic [9:0]         Doodle_X_in,
   input  logic [9:0]         Doodle_Y_in,
   input  logic               Doodle_falling,
   input  logic [PLAT_IW-1:0] Plat_rd_idx,
   output logic [9:0]         Plat_X_out,
   output logic [9:0]         Plat_Y_out,
   output logic [3:0]         Scroll_amt,
   output logic               Bounce,
   output logic [15:0]        Score,
   output logic               Game_over,
   output logic               Busy
);

   // All geometry compares run at 11 bits so sums never wrap.
   localparam logic [10:0] H11   = 11'(H);
   localparam logic [10:0] SL11  = 11'(SCROLL_LINE);
   localparam logic [10:0] SMX11 = 11'(SCROLL_MAX);
   localparam logic [10:0] DH11  = 11'(DOODLE_H);
   localparam logic [10:0] DW11  = 11'(DOODLE_W);
   localparam logic [10:0] PH11  = 11'(PLAT_H);
   localparam logic [10:0] PW11  = 11'(PLAT_W);
   localparam logic [PLAT_IW-1:0] LAST_IDX = PLAT_IW'(N_PLAT - 1);

   pf_state_e          state_q;
   plat_t              plat_q [N_PLAT];
   logic [PLAT_IW-1:0] idx_q;
   logic [9:0]         dx_q, dy_q;
   logic               dfall_q;
   logic [3:0]         s_q;
   logic               hit_q;
   logic [3:0]         scroll_q;
   logic               bounce_q;
   logic [15:0]        score_q;
   logic               go_q;

   logic [15:0] lfsr_state;
   logic        lfsr_step;
   logic        lfsr_unused;

   // Sample-stage signals from the live doodle inputs.
   logic [10:0] yin11, diff;
   logic        fell_out;
   logic [3:0]  s_new;

   // Sweep-stage signals for the platform under idx_q.
   plat_t       cur, plat_nxt;
   logic [10:0] dbot, drgt, dlft, ptop, pbot, plft, prgt, ny;
   logic        hit_i, wrap;
   logic [16:0] score_sum;
   logic [15:0] score_nxt;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk_i   (Clk),
      .rst_ni  (Reset_n),
      .step_i  (lfsr_step),
      .state_o (lfsr_state)
   );

   assign lfsr_unused = ^lfsr_state[15:7];

   // Fall-out test and clamped scroll amount for the frame being started.
   always_comb begin
      yin11    = {1'b0, Doodle_Y_in};
      fell_out = (yin11 + DH11) > (H11 - 11'd2);
      diff     = SL11 - yin11;
      s_new    = 4'd0;
      if (yin11 < SL11) s_new = (diff > SMX11) ? 4'(SCROLL_MAX) : 4'(diff);
   end

   // Landing and scroll/wrap of the current platform, using its pre-scroll Y.
   always_comb begin
      cur   = plat_q[idx_q];
      dbot  = {1'b0, dy_q} + DH11;
      dlft  = {1'b0, dx_q};
      drgt  = dlft + DW11;
      ptop  = {1'b0, cur.y};
      pbot  = ptop + PH11;
      plft  = {1'b0, cur.x};
      prgt  = plft + PW11;
      hit_i = dfall_q & (dbot >= ptop) & (dbot < pbot) & (drgt > plft) & (dlft < prgt);
      ny    = ptop + {7'd0, s_q};
      wrap  = (ny >= H11);
      plat_nxt = cur;
      if (wrap) begin
         // Subtracting H keeps the 30 px pitch; 7 LFSR bits exactly span the legal X range.
         plat_nxt.y = 10'(ny - H11);
         plat_nxt.x = 10'(X_MIN) + {3'd0, lfsr_state[6:0]};
      end else begin
         plat_nxt.y = 10'(ny);
      end
   end

   assign lfsr_step = (state_q == PF_SWEEP) && wrap;

   // Saturating score accumulation.
   always_comb begin
      score_sum = {1'b0, score_q} + {13'd0, s_q};
      score_nxt = score_sum[16] ? 16'hFFFF : score_sum[15:0];
   end

   // Frame FSM: sample doodle, sweep one platform per cycle, then publish results.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q  <= PF_IDLE;
         idx_q    <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         dfall_q  <= 1'b0;
         s_q      <= '0;
         hit_q    <= 1'b0;
         scroll_q <= '0;
         bounce_q <= 1'b0;
         score_q  <= '0;
         go_q     <= 1'b0;
         for (int i = 0; i < N_PLAT; i++) plat_q[i] <= plat_init(i);
      end else begin
         bounce_q <= 1'b0;
         case (state_q)
            PF_IDLE: begin
               if (frame_clk_edge == 2'b01 && !go_q) state_q <= PF_SAMPLE;
            end
            PF_SAMPLE: begin
               if (fell_out) begin
                  go_q    <= 1'b1;
                  state_q <= PF_IDLE;
               end else begin
                  dx_q    <= Doodle_X_in;
                  dy_q    <= Doodle_Y_in;
                  dfall_q <= Doodle_falling;
                  s_q     <= s_new;
                  hit_q   <= 1'b0;
                  idx_q   <= '0;
                  state_q <= PF_SWEEP;
               end
            end
            PF_SWEEP: begin
               hit_q         <= hit_q | hit_i;
               plat_q[idx_q] <= plat_nxt;
               if (idx_q == LAST_IDX) state_q <= PF_DONE;
               else                   idx_q   <= idx_q + 1'b1;
            end
            PF_DONE: begin
               scroll_q <= s_q;
               bounce_q <= hit_q;
               score_q  <= score_nxt;
               state_q  <= PF_IDLE;
            end
            default: state_q <= PF_IDLE;
         endcase
      end
   end

   assign Plat_X_out = plat_q[Plat_rd_idx].x;
   assign Plat_Y_out = plat_q[Plat_rd_idx].y;
   assign Scroll_amt = scroll_q;
   assign Bounce     = bounce_q;
   assign Score      = score_q;
   assign Game_over  = go_q;
   assign Busy       = (state_q != PF_IDLE);

endmodule

// File: tb/tb_platform_field.sv
// Directed bench for platform_field with a small spec-level world model.
module tb_platform_field;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic [1:0] frame_clk_edge = 2'b00;
   logic [9:0] Doodle_X_in = '0;
   logic [9:0] Doodle_Y_in = '0;
   logic       Doodle_falling = 1'b0;
   logic [2:0] Plat_rd_idx = '0;
   logic [9:0] Plat_X_out, Plat_Y_out;
   logic [3:0] Scroll_amt;
   logic       Bounce;
   logic [15:0] Score;
   logic       Game_over;
   logic       Busy;

   platform_field dut (
      .Clk            (Clk),
      .Reset_n        (Reset_n),
      .frame_clk_edge (frame_clk_edge),
      .Doodle_X_in    (Doodle_X_in),
      .Doodle_Y_in    (Doodle_Y_in),
      .Doodle_falling (Doodle_falling),
      .Plat_rd_idx    (Plat_rd_idx),
      .Plat_X_out     (Plat_X_out),
      .Plat_Y_out     (Plat_Y_out),
      .Scroll_amt     (Scroll_amt),
      .Bounce         (Bounce),
      .Score          (Score),
      .Game_over      (Game_over),
      .Busy           (Busy)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int failures = 0;

   int          mx [8];
   int          my [8];
   logic [15:0] mlfsr;
   int          mscore;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_nx(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         my[i] = 210 - 30 * i;
         mx[i] = 80 + ((37 * i + 64) % 128);
      end
      mlfsr  = 16'hACE1;
      mscore = 0;
   endtask

   task automatic model_frame(input int x, input int y, input bit f, output int s, output bit hit);
      int ny;
      s   = (y < 80) ? (((80 - y) > 15) ? 15 : (80 - y)) : 0;
      hit = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (f && (y + 10 >= my[i]) && (y + 10 < my[i] + 4) && (x + 10 > mx[i]) && (x < mx[i] + 32))
            hit = 1'b1;
         ny = my[i] + s;
         if (ny >= 240) begin
            my[i] = ny - 240;
            mx[i] = 80 + int'(mlfsr[6:0]);
            mlfsr = lfsr_nx(mlfsr);
         end else begin
            my[i] = ny;
         end
      end
      mscore = (mscore + s > 65535) ? 65535 : mscore + s;
   endtask

   // Tick once and wait (bounded) for Busy to drop; lat = cycles from tick edge to idle.
   task automatic frame(input int x, input int y, input bit f, input bit retick,
                        output int lat, output bit bnc);
      Doodle_X_in    = 10'(x);
      Doodle_Y_in    = 10'(y);
      Doodle_falling = f;
      frame_clk_edge = 2'b01;
      @(posedge Clk); #1;
      lat = 0;
      bnc = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         frame_clk_edge = (retick && c == 3) ? 2'b01 : 2'b00;
         @(posedge Clk); #1;
         if (!Busy) begin
            lat = c;
            bnc = Bounce;
            break;
         end
      end
      frame_clk_edge = 2'b00;
      if (lat == 0) chk("frame_done", {31'd0, Busy}, 32'd0);
   endtask

   task automatic check_plats(input string tag);
      for (int i = 0; i < 8; i++) begin
         Plat_rd_idx = 3'(i);
         @(negedge Clk);
         chk($sformatf("%s_x%0d", tag, i), {22'd0, Plat_X_out}, mx[i]);
         chk($sformatf("%s_y%0d", tag, i), {22'd0, Plat_Y_out}, my[i]);
      end
      @(posedge Clk); #1;
   endtask

   task automatic read_plat(input int i);
      Plat_rd_idx = 3'(i);
      @(negedge Clk);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      bit bnc;
      int s;
      bit hit;

      // Reset state
      Reset_n = 1'b0;
      repeat (3) @(posedge Clk);
      #1 Reset_n = 1'b1;
      chk("rst_scroll", {28'd0, Scroll_amt}, 0);
      chk("rst_bounce", {31'd0, Bounce}, 0);
      chk("rst_score", {16'd0, Score}, 0);
      chk("rst_gameover", {31'd0, Game_over}, 0);
      chk("rst_busy", {31'd0, Busy}, 0);
      read_plat(0);
      chk("rst_p0x", {22'd0, Plat_X_out}, 144);
      chk("rst_p0y", {22'd0, Plat_Y_out}, 210);
      read_plat(7);
      chk("rst_p7x", {22'd0, Plat_X_out}, 147);
      chk("rst_p7y", {22'd0, Plat_Y_out}, 0);
      @(posedge Clk); #1;
      model_reset();
      check_plats("rst");

      // Landing on plat 0, Bounce 10 cycles after tick, one cycle wide
      frame(150, 200, 1'b1, 1'b0, lat, bnc);
      model_frame(150, 200, 1'b1, s, hit);
      chk("land_latency", lat, 10);
      chk("land_bounce", {31'd0, bnc}, 1);
      @(posedge Clk); #1;
      chk("land_bounce_width", {31'd0, Bounce}, 0);
      chk("land_scroll", {28'd0, Scroll_amt}, 0);

      // Same spot, not falling
      frame(150, 200, 1'b0, 1'b0, lat, bnc);
      model_frame(150, 200, 1'b0, s, hit);
      chk("nofall_bounce", {31'd0, bnc}, 0);

      // Clamped scroll
      frame(150, 60, 1'b0, 1'b0, lat, bnc);
      model_frame(150, 60, 1'b0, s, hit);
      chk("scroll15_amt", {28'd0, Scroll_amt}, 15);
      chk("scroll15_score", {16'd0, Score}, 15);
      read_plat(0);
      chk("scroll15_p0y", {22'd0, Plat_Y_out}, 225);
      @(posedge Clk); #1;
      check_plats("scroll15");

      // Unclamped scroll
      frame(150, 75, 1'b0, 1'b0, lat, bnc);
      model_frame(150, 75, 1'b0, s, hit);
      chk("scroll5_amt", {28'd0, Scroll_amt}, 5);
      chk("scroll5_score", {16'd0, Score}, 20);
      read_plat(0);
      chk("scroll5_p0y", {22'd0, Plat_Y_out}, 230);
      @(posedge Clk); #1;

      // Plat 0 wraps: Y 230+15 -> 5, X from seed low bits (0x61 = 97)
      frame(150, 60, 1'b0, 1'b0, lat, bnc);
      model_frame(150, 60, 1'b0, s, hit);
      read_plat(0);
      chk("wrap1_p0y", {22'd0, Plat_Y_out}, 5);
      chk("wrap1_p0x", {22'd0, Plat_X_out}, 177);
      chk("wrap1_xrange", {31'd0, (Plat_X_out >= 10'd80 && Plat_X_out <= 10'd207)}, 1);
      @(posedge Clk); #1;
      check_plats("wrap1");

      // Two more frames; plat 1 wraps with the once-stepped LFSR (0x59C3 -> 67)
      frame(150, 60, 1'b0, 1'b0, lat, bnc);
      model_frame(150, 60, 1'b0, s, hit);
      frame(150, 60, 1'b0, 1'b0, lat, bnc);
      model_frame(150, 60, 1'b0, s, hit);
      chk("wrap2_score", {16'd0, Score}, 65);
      read_plat(1);
      chk("wrap2_p1y", {22'd0, Plat_Y_out}, 5);
      chk("wrap2_p1x", {22'd0, Plat_X_out}, 147);
      @(posedge Clk); #1;
      check_plats("wrap2");

      // Tick repeated while Busy is ignored
      frame(150, 75, 1'b0, 1'b1, lat, bnc);
      model_frame(150, 75, 1'b0, s, hit);
      chk("retick_latency", lat, 10);
      repeat (3) @(posedge Clk);
      #1;
      chk("retick_busy", {31'd0, Busy}, 0);
      chk("retick_score", {16'd0, Score}, 70);

      // Landing judged on pre-scroll Y: plat 7 at Y=70, doodle bottom 70, scroll 15
      frame(150, 60, 1'b1, 1'b0, lat, bnc);
      model_frame(150, 60, 1'b1, s, hit);
      chk("prescroll_bounce", {31'd0, bnc}, 1);
      chk("prescroll_score", {16'd0, Score}, 85);
      read_plat(7);
      chk("prescroll_p7y", {22'd0, Plat_Y_out}, 85);
      @(posedge Clk); #1;
      check_plats("prescroll");

      // Reset in the middle of a sweep
      Doodle_Y_in    = 10'd60;
      frame_clk_edge = 2'b01;
      @(posedge Clk); #1;
      frame_clk_edge = 2'b00;
      repeat (4) @(posedge Clk);
      #1 Reset_n = 1'b0;
      @(posedge Clk); #1;
      Reset_n = 1'b1;
      chk("midrst_busy", {31'd0, Busy}, 0);
      chk("midrst_score", {16'd0, Score}, 0);
      chk("midrst_scroll", {28'd0, Scroll_amt}, 0);
      model_reset();
      check_plats("midrst");

      // Score saturation: 4368*15 + 8 = 0xFFF8, then +15 saturates
      for (int k = 0; k < 4368; k++) begin
         frame(150, 60, 1'b0, 1'b0, lat, bnc);
         model_frame(150, 60, 1'b0, s, hit);
      end
      frame(150, 72, 1'b0, 1'b0, lat, bnc);
      model_frame(150, 72, 1'b0, s, hit);
      chk("sat_pre", {16'd0, Score}, 32'hFFF8);
      chk("sat_pre_amt", {28'd0, Scroll_amt}, 8);
      frame(150, 60, 1'b0, 1'b0, lat, bnc);
      model_frame(150, 60, 1'b0, s, hit);
      chk("sat_hit", {16'd0, Score}, 32'hFFFF);
      frame(150, 60, 1'b0, 1'b0, lat, bnc);
      model_frame(150, 60, 1'b0, s, hit);
      chk("sat_hold", {16'd0, Score}, 32'hFFFF);
      check_plats("sat");

      // Boundary just inside the screen: 228+10 = 238, no game over
      frame(150, 228, 1'b0, 1'b0, lat, bnc);
      model_frame(150, 228, 1'b0, s, hit);
      chk("edge228_go", {31'd0, Game_over}, 0);
      chk("edge228_amt", {28'd0, Scroll_amt}, 0);

      // Fall out: 229+10 > 238
      frame(150, 229, 1'b0, 1'b0, lat, bnc);
      chk("go_latency", lat, 1);
      chk("go_flag", {31'd0, Game_over}, 1);
      chk("go_busy", {31'd0, Busy}, 0);
      check_plats("go_frozen");
      Doodle_Y_in    = 10'd60;
      frame_clk_edge = 2'b01;
      @(posedge Clk); #1;
      frame_clk_edge = 2'b00;
      chk("go_tick_ignored", {31'd0, Busy}, 0);
      repeat (12) @(posedge Clk);
      #1;
      chk("go_score_frozen", {16'd0, Score}, 32'hFFFF);
      chk("go_sticky", {31'd0, Game_over}, 1);
      check_plats("go_frozen2");

      // Reset clears game over
      Reset_n = 1'b0;
      @(posedge Clk); #1;
      Reset_n = 1'b1;
      chk("go_rst_flag", {31'd0, Game_over}, 0);
      chk("go_rst_score", {16'd0, Score}, 0);
      model_reset();
      check_plats("go_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
